// File: rtl/router_ingress_pipe.sv
// ---------------------------------------------------------------------------
// router_ingress_pipe
//
// Parametrised ingress stage of the router. A shared flit bus is written into
// one small FIFO per port, selected by one-hot (or multi-hot) write strobes.
// On every advance pulse each port's FIFO head moves into that port's output
// register, tagged with a valid bit and a 2-bit age. An empty FIFO produces an
// all-zero bubble instead. The outputs feed the arbitration/permutation stage.
//
// Parameters
//   NUM_PORTS : number of ports (default 5: 0=N, 1=S, 2=E, 3=W, 4=L)
//   FLIT_W    : flit payload width
//   DEPTH     : FIFO entries per port, power of two, at least 2
//   OUT_W     : derived output word width per port (FLIT_W + 3), internal only
//
// Ports
//   clksig   in   clock, rising edge
//   rstsig   in   synchronous active-high reset
//   inc      in   shared input flit bus [FLIT_W]
//   wr_sig   in   per-port write strobe [NUM_PORTS]
//   adv      in   pipeline advance: pop every non-empty FIFO into its output
//   out_bus  out  port p at [p*OUT_W +: OUT_W], format {vld, age[1:0], flit}
//   full     out  per-port FIFO full, registered
//   empty    out  per-port FIFO empty, registered
//   drop_cnt out  per-port 8-bit saturating count of dropped writes,
//                 port p at [p*8 +: 8]; present only when the macro
//                 ROUTER_INGRESS_DROP_CNT_EN is defined
// ---------------------------------------------------------------------------
module router_ingress_pipe #(
  parameter int NUM_PORTS = 5,
  parameter int FLIT_W    = 7,
  parameter int DEPTH     = 2
) (
  input  logic                              clksig,
  input  logic                              rstsig,
  input  logic [FLIT_W-1:0]                 inc,
  input  logic [NUM_PORTS-1:0]              wr_sig,
  input  logic                              adv,
  output logic [NUM_PORTS*(FLIT_W+3)-1:0]   out_bus,
  output logic [NUM_PORTS-1:0]              full,
  output logic [NUM_PORTS-1:0]              empty
`ifdef ROUTER_INGRESS_DROP_CNT_EN
  ,
  output logic [NUM_PORTS*8-1:0]            drop_cnt
`endif
);

  localparam int OUT_W = FLIT_W + 3;
  localparam int AW    = $clog2(DEPTH);

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port

    // Storage for flit payloads and the age tag of each slot. Slot ages are
    // aged unconditionally; a slot's age is forced to 0 when it is written,
    // so stale ages in unoccupied slots never become visible.
    logic [FLIT_W-1:0] r_mem [DEPTH];
    logic [1:0]        r_age [DEPTH];

    // Pointers carry one extra wrap bit so full and empty can be told apart
    // when the index bits are equal.
    logic [AW:0]       r_wptr;
    logic [AW:0]       r_rptr;
    logic              r_full;
    logic              r_empty;
    logic [OUT_W-1:0]  r_out;

    logic              w_push;
    logic              w_pop;
    logic [AW:0]       w_wptrNext;
    logic [AW:0]       w_rptrNext;
    logic [AW-1:0]     w_wIdx;
    logic [AW-1:0]     w_rIdx;

    // Push/pop decisions for this port. A write to a full FIFO is still
    // accepted when an advance in the same cycle pops the head, because a
    // full FIFO is never empty and the pop frees exactly one slot.
    always_comb begin
      w_pop      = adv & ~r_empty;
      w_push     = wr_sig[p] & (~r_full | adv);
      w_wIdx     = r_wptr[AW-1:0];
      w_rIdx     = r_rptr[AW-1:0];
      w_wptrNext = r_wptr + {{AW{1'b0}}, w_push};
      w_rptrNext = r_rptr + {{AW{1'b0}}, w_pop};
    end

    // Pointer, flag, age and output-register update. The flags are computed
    // from the next pointer values so they describe occupancy after the edge.
    // The head is read from the current pointer, so a flit written on this
    // edge cannot be popped until the following edge (no bypass).
    always_ff @(posedge clksig) begin
      if (rstsig) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_full  <= 1'b0;
        r_empty <= 1'b1;
        r_out   <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          r_age[i] <= 2'd0;
        end
      end else begin
        r_wptr  <= w_wptrNext;
        r_rptr  <= w_rptrNext;
        r_full  <= (w_wptrNext[AW] != w_rptrNext[AW]) &&
                   (w_wptrNext[AW-1:0] == w_rptrNext[AW-1:0]);
        r_empty <= (w_wptrNext == w_rptrNext);

        for (int i = 0; i < DEPTH; i++) begin
          r_age[i] <= (r_age[i] == 2'd3) ? 2'd3 : r_age[i] + 2'd1;
        end

        if (w_push) begin
          r_mem[w_wIdx] <= inc;
          r_age[w_wIdx] <= 2'd0;
        end

        if (adv) begin
          r_out <= w_pop ? {1'b1, r_age[w_rIdx], r_mem[w_rIdx]} : '0;
        end
      end
    end

    assign out_bus[p*OUT_W +: OUT_W] = r_out;
    assign full[p]                   = r_full;
    assign empty[p]                  = r_empty;

`ifdef ROUTER_INGRESS_DROP_CNT_EN
    logic [7:0] r_dropCnt;
    logic       w_drop;

    // A drop is a write strobe that finds the FIFO full with no pop to make
    // room in the same cycle.
    always_comb begin
      w_drop = wr_sig[p] & r_full & ~adv;
    end

    // Saturating drop counter, cleared by reset.
    always_ff @(posedge clksig) begin
      if (rstsig) begin
        r_dropCnt <= 8'd0;
      end else if (w_drop && (r_dropCnt != 8'hFF)) begin
        r_dropCnt <= r_dropCnt + 8'd1;
      end
    end

    assign drop_cnt[p*8 +: 8] = r_dropCnt;
`endif

  end : g_port

endmodule

// File: tb/tb_router_ingress_pipe.sv
// ---------------------------------------------------------------------------
// tb_router_ingress_pipe
//
// Directed self-checking bench for router_ingress_pipe at default parameters
// (5 ports, 7-bit flits, depth 2). Each scenario task drives stimulus on the
// falling edge and compares outputs on the falling edge after the rising edge.
// ---------------------------------------------------------------------------
module tb_router_ingress_pipe;

  localparam int NUM_PORTS = 5;
  localparam int FLIT_W    = 7;
  localparam int OUT_W     = FLIT_W + 3;
  localparam int BUS_W     = NUM_PORTS * OUT_W;

  logic                   clksig;
  logic                   rstsig;
  logic [FLIT_W-1:0]      inc;
  logic [NUM_PORTS-1:0]   wr_sig;
  logic                   adv;
  logic [BUS_W-1:0]       out_bus;
  logic [NUM_PORTS-1:0]   full;
  logic [NUM_PORTS-1:0]   empty;
`ifdef ROUTER_INGRESS_DROP_CNT_EN
  logic [NUM_PORTS*8-1:0] drop_cnt;
`endif

  int checkCount = 0;
  int passCount  = 0;

  logic [BUS_W-1:0] expBus;

  router_ingress_pipe #(
    .NUM_PORTS(NUM_PORTS),
    .FLIT_W   (FLIT_W),
    .DEPTH    (2)
  ) dut (
    .clksig  (clksig),
    .rstsig  (rstsig),
    .inc     (inc),
    .wr_sig  (wr_sig),
    .adv     (adv),
    .out_bus (out_bus),
    .full    (full),
    .empty   (empty)
`ifdef ROUTER_INGRESS_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial begin
    clksig = 1'b0;
    forever #5 clksig = ~clksig;
  end

  // One rising edge, then return at the falling edge where outputs are stable.
  task automatic tick();
    @(posedge clksig);
    @(negedge clksig);
  endtask

  task automatic test_reset();
    rstsig = 1'b1;
    wr_sig = '0;
    adv    = 1'b0;
    inc    = '0;
    tick();
    tick();
    checkCount++;
    if (out_bus !== '0) $display("[TB] FAIL reset_out: got %h want 0", out_bus);
    else passCount++;
    checkCount++;
    if (empty !== 5'b11111) $display("[TB] FAIL reset_empty: got %b want 11111", empty);
    else passCount++;
    checkCount++;
    if (full !== 5'b00000) $display("[TB] FAIL reset_full: got %b want 00000", full);
    else passCount++;
`ifdef ROUTER_INGRESS_DROP_CNT_EN
    checkCount++;
    if (drop_cnt !== '0) $display("[TB] FAIL reset_drop: got %h want 0", drop_cnt);
    else passCount++;
`endif
    rstsig = 1'b0;
    adv    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkCount++;
      if (out_bus !== '0 || empty !== 5'b11111 || full !== 5'b00000)
        $display("[TB] FAIL idle_adv%0d: got out=%h empty=%b full=%b want 0/11111/00000",
                 i, out_bus, empty, full);
      else passCount++;
    end
    adv = 1'b0;
  endtask

  task automatic test_single_write();
    inc    = 7'b0000101;
    wr_sig = 5'b00001;
    tick();
    wr_sig = '0;
    checkCount++;
    if (empty !== 5'b11110 || full !== 5'b00000)
      $display("[TB] FAIL single_flags: got empty=%b full=%b want 11110/00000", empty, full);
    else passCount++;
    checkCount++;
    if (out_bus !== '0) $display("[TB] FAIL single_nobypass: got %h want 0", out_bus);
    else passCount++;
    adv = 1'b1;
    tick();
    adv = 1'b0;
    expBus = '0;
    expBus[0 +: OUT_W] = 10'b1_00_0000101;
    checkCount++;
    if (out_bus !== expBus) $display("[TB] FAIL single_out: got %h want %h", out_bus, expBus);
    else passCount++;
    checkCount++;
    if (empty !== 5'b11111) $display("[TB] FAIL single_empty_after: got %b want 11111", empty);
    else passCount++;
  endtask

  task automatic test_aging();
    inc    = 7'b1100001;
    wr_sig = 5'b00100;
    tick();
    wr_sig = '0;
    for (int i = 0; i < 5; i++) tick();
    // Output registers hold their previous contents while adv is low.
    expBus = '0;
    expBus[0 +: OUT_W] = 10'b1_00_0000101;
    checkCount++;
    if (out_bus !== expBus) $display("[TB] FAIL aging_hold: got %h want %h", out_bus, expBus);
    else passCount++;
    adv = 1'b1;
    tick();
    adv = 1'b0;
    expBus = '0;
    expBus[2*OUT_W +: OUT_W] = 10'b1_11_1100001;
    checkCount++;
    if (out_bus !== expBus) $display("[TB] FAIL aging_out: got %h want %h", out_bus, expBus);
    else passCount++;
  endtask

  task automatic test_full_drop();
    inc    = 7'b0100100;
    wr_sig = 5'b01000;
    tick();
    checkCount++;
    if (full !== 5'b00000 || empty !== 5'b10111)
      $display("[TB] FAIL drop_first_flags: got full=%b empty=%b want 00000/10111", full, empty);
    else passCount++;
    inc = 7'b0100111;
    tick();
    checkCount++;
    if (full !== 5'b01000) $display("[TB] FAIL drop_full: got %b want 01000", full);
    else passCount++;
    inc = 7'b0011100;
    tick();
    wr_sig = '0;
    checkCount++;
    if (full !== 5'b01000) $display("[TB] FAIL drop_full_held: got %b want 01000", full);
    else passCount++;
`ifdef ROUTER_INGRESS_DROP_CNT_EN
    checkCount++;
    if (drop_cnt[3*8 +: 8] !== 8'd1) $display("[TB] FAIL drop_cnt3: got %0d want 1", drop_cnt[3*8 +: 8]);
    else passCount++;
`endif
    adv = 1'b1;
    tick();
    expBus = '0;
    expBus[3*OUT_W +: OUT_W] = 10'b1_10_0100100;
    checkCount++;
    if (out_bus !== expBus) $display("[TB] FAIL drop_pop1: got %h want %h", out_bus, expBus);
    else passCount++;
    checkCount++;
    if (full !== 5'b00000 || empty !== 5'b10111)
      $display("[TB] FAIL drop_pop1_flags: got full=%b empty=%b want 00000/10111", full, empty);
    else passCount++;
    tick();
    expBus = '0;
    expBus[3*OUT_W +: OUT_W] = 10'b1_10_0100111;
    checkCount++;
    if (out_bus !== expBus) $display("[TB] FAIL drop_pop2: got %h want %h", out_bus, expBus);
    else passCount++;
    tick();
    adv = 1'b0;
    checkCount++;
    if (out_bus !== '0 || empty !== 5'b11111)
      $display("[TB] FAIL drop_pop3: got out=%h empty=%b want 0/11111", out_bus, empty);
    else passCount++;
  endtask

  task automatic test_push_pop_full();
    wr_sig = 5'b10000;
    inc    = 7'b0000011;
    tick();
    inc    = 7'b0000110;
    tick();
    checkCount++;
    if (full !== 5'b10000) $display("[TB] FAIL pp_full_before: got %b want 10000", full);
    else passCount++;
    inc = 7'b0111111;
    adv = 1'b1;
    tick();
    wr_sig = '0;
    expBus = '0;
    expBus[4*OUT_W +: OUT_W] = 10'b1_01_0000011;
    checkCount++;
    if (out_bus !== expBus) $display("[TB] FAIL pp_head: got %h want %h", out_bus, expBus);
    else passCount++;
    checkCount++;
    if (full !== 5'b10000) $display("[TB] FAIL pp_full_after: got %b want 10000", full);
    else passCount++;
`ifdef ROUTER_INGRESS_DROP_CNT_EN
    checkCount++;
    if (drop_cnt[4*8 +: 8] !== 8'd0) $display("[TB] FAIL pp_drop_cnt4: got %0d want 0", drop_cnt[4*8 +: 8]);
    else passCount++;
`endif
    tick();
    expBus = '0;
    expBus[4*OUT_W +: OUT_W] = 10'b1_01_0000110;
    checkCount++;
    if (out_bus !== expBus) $display("[TB] FAIL pp_second: got %h want %h", out_bus, expBus);
    else passCount++;
    tick();
    adv = 1'b0;
    expBus = '0;
    expBus[4*OUT_W +: OUT_W] = 10'b1_01_0111111;
    checkCount++;
    if (out_bus !== expBus) $display("[TB] FAIL pp_new_flit: got %h want %h", out_bus, expBus);
    else passCount++;
    checkCount++;
    if (empty !== 5'b11111 || full !== 5'b00000)
      $display("[TB] FAIL pp_drained: got empty=%b full=%b want 11111/00000", empty, full);
    else passCount++;
  endtask

  task automatic test_broadcast_reset();
    inc    = 7'b0000001;
    wr_sig = 5'b00010;
    tick();
    inc    = 7'b0101100;
    wr_sig = 5'b11111;
    adv    = 1'b1;
    tick();
    wr_sig = '0;
    expBus = '0;
    expBus[1*OUT_W +: OUT_W] = 10'b1_00_0000001;
    checkCount++;
    if (out_bus !== expBus) $display("[TB] FAIL bc_out: got %h want %h", out_bus, expBus);
    else passCount++;
    checkCount++;
    if (empty !== 5'b00000 || full !== 5'b00000)
      $display("[TB] FAIL bc_flags: got empty=%b full=%b want 00000/00000", empty, full);
    else passCount++;
    rstsig = 1'b1;
    tick();
    rstsig = 1'b0;
    checkCount++;
    if (out_bus !== '0 || empty !== 5'b11111 || full !== 5'b00000)
      $display("[TB] FAIL bc_reset: got out=%h empty=%b full=%b want 0/11111/00000",
               out_bus, empty, full);
    else passCount++;
    tick();
    adv = 1'b0;
    checkCount++;
    if (out_bus !== '0) $display("[TB] FAIL bc_discarded: got %h want 0", out_bus);
    else passCount++;
  endtask

  initial begin
    rstsig = 1'b1;
    inc    = '0;
    wr_sig = '0;
    adv    = 1'b0;
    @(negedge clksig);
    test_reset();
    test_single_write();
    test_aging();
    test_full_drop();
    test_push_pop_full();
    test_broadcast_reset();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/router_ingress_pipe.md
Name: router_ingress_pipe

Overview:
- Parametrised ingress pipeline for the router. Generalises the fixed five-port, 7-bit input stage.
- A shared input flit bus is written into per-port FIFOs using one-hot write strobes.
- On each advance pulse, every port's FIFO head moves into an output register, tagged with a valid bit and a 2-bit age field.
- Sits between the link receivers and the router's arbitration/permutation stage.

Parameters:
- NUM_PORTS, 5, number of ports (index 0=N, 1=S, 2=E, 3=W, 4=L at default).
- FLIT_W, 7, flit payload width in bits.
- DEPTH, 2, FIFO entries per port (power of two, >=2).
- OUT_W, FLIT_W+3, output word width per port (derived; not to be overridden).

Ports:
- clksig  input  1  clock, rising edge.
- rstsig  input  1  synchronous, active-high reset.
- inc  input  FLIT_W  shared input flit bus.
- wr_sig  input  NUM_PORTS  per-port write strobe. Bit p=1 captures inc into FIFO p.
- adv  input  1  pipeline advance. Pops every non-empty FIFO into its output register.
- out_bus  output  NUM_PORTS*OUT_W  port p occupies bits [p*OUT_W +: OUT_W]. Format {vld, age[1:0], flit}.
- full  output  NUM_PORTS  per-port FIFO full, registered.
- empty  output  NUM_PORTS  per-port FIFO empty, registered.

Behaviour:
- Reset (rstsig=1 at an edge):
  - all FIFOs emptied, all pointers and ages cleared.
  - out_bus=0, full=0, empty=all ones.
  - reset overrides wr_sig and adv in the same cycle. Mid-operation reset discards all stored flits.
- Write:
  - at an edge with wr_sig[p]=1 and FIFO p not full, inc is stored at the tail with age 0.
  - several wr_sig bits high in one cycle broadcast the same inc into each selected FIFO.
- Write to a full FIFO:
  - flit dropped; FIFO contents and full flag unchanged.
  - exception: when adv=1 in the same cycle, the pop frees a slot and the write is accepted.
- Advance (adv=1 at an edge), per port:
  - non-empty FIFO: output register loads {1'b1, head_age, head_flit} and the head is popped.
  - empty FIFO: output register loads all zeros (bubble).
- adv=0: output registers hold their value; no pops.
- No bypass: a flit written at edge k is first poppable at edge k+1. Minimum write-to-out_bus latency is 2 edges: capture edge plus advance edge.
- Age:
  - every resident entry not popped at an edge increments its age, saturating at 3.
  - an entry popped at the first edge after capture reports age 0.
- Pointers:
  - read and write pointers are log2(DEPTH) bits with an extra wrap bit.
  - full when the pointers differ only in the wrap bit; empty when the pointers are equal.
  - wrap-around at DEPTH is seamless.
- Flags:
  - full and empty are registered and reflect occupancy after the edge.
  - simultaneous push and pop leaves occupancy unchanged.
- X/Z on inc is stored as-is when written; when not written, it has no effect.

Optional Feature:
- Macro: ROUTER_INGRESS_DROP_CNT_EN.
- When defined:
  - adds output drop_cnt, width NUM_PORTS*8, with port p at [p*8 +: 8].
  - an 8-bit per-port counter increments at each edge where wr_sig[p]=1 and the write is dropped (full, no same-cycle pop).
  - the counter saturates at 255 and is cleared by rstsig.
- When undefined: the port and counters are absent; drop behaviour is otherwise identical.

Test Plan:
1. Reset then idle
   - Stimulus: rstsig=1 for 2 edges, then adv=1 with no writes.
   - Required: out_bus=0 every cycle, empty=5'b11111, full=0.
2. Single write, immediate advance
   - Stimulus: inc=7'b0000101, wr_sig=5'b00001 at edge 1; adv=1 at edge 2.
   - Required: port 0 out = 10'b1_00_0000101; ports 1-4 = 0.
3. Aging
   - Stimulus: write 7'b1100001 to port 2 (E), then hold adv=0 for 5 edges, then adv=1.
   - Required: port 2 out = 10'b1_11_1100001 (age saturated at 3).
4. Full and drop
   - Stimulus: three consecutive writes to port 3 (W) of 7'b0100100, 7'b0100111, 7'b0011100 with adv=0.
   - Required: full[3]=1 after the second write; the third write is dropped (drop_cnt[3]=1 when the macro is defined).
   - Then two adv pulses: port 3 shows 7'b0100100, then 7'b0100111. The third adv outputs 0.
5. Push+pop on a full FIFO
   - Stimulus: port 4 (L) full; same edge wr_sig[4]=1, inc=7'b0111111, adv=1.
   - Required: the old head is output, the new flit is accepted, full[4] stays 1, no drop counted.
6. Broadcast and mid-operation reset
   - Stimulus: wr_sig=5'b11111 with inc=7'b0101100; rstsig=1 on the next edge together with adv=1.
   - Required: out_bus=0 and empty=5'b11111 after the reset edge.
